prog_loader: RTL and testbench

Boot-time program loader placed directly upstream of `single_cycle_processor`. It receives a little-endian byte stream over a valid/ready port and assembles it into 32-bit words. It writes those words into the processor's instruction memory and holds the processor in reset until the image is fully loaded. On success it releases the processor to fetch from `BASE_ADDR`. On a malformed image it parks in an error state with the processor still held in reset.

---
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 132 +++++++++++++
 tb/tb_prog_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write bus
// for the boot-time program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_byte,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles a little-endian byte stream into imem words and
// holds the CPU in reset until loaded. LOADER_CHECKSUM_EN adds XOR check.
module prog_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         cpu_rst,
    output logic         done,
    output logic         err
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR, S_LOAD, S_CHK, S_RUN, S_ERR
    } state_t;
    localparam state_t S_POST = S_CHK;
`else
    typedef enum logic [2:0] {
        S_HDR, S_LOAD, S_RUN, S_ERR
    } state_t;
    localparam state_t S_POST = S_RUN;
`endif

    localparam logic [32:0] MAXN =
        33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

    state_t            state, state_n;
    logic [1:0]        bcnt;
    logic [23:0]       sh;
    logic [31:0]       word;
    logic [ADDR_W:0]   nwords;
    logic [ADDR_W:0]   idx;
    logic              accept;
    logic              wdone;
    logic              busy;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       acc;
`endif

`ifdef LOADER_CHECKSUM_EN
    assign busy = (state == S_HDR) || (state == S_LOAD) ||
                  (state == S_CHK);
`else
    assign busy = (state == S_HDR) || (state == S_LOAD);
`endif

    assign bus.in_ready   = !rst && busy;
    assign accept         = bus.in_valid && bus.in_ready;
    assign wdone          = accept && (bcnt == 2'd3);
    assign word           = {bus.in_byte, sh};
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_HDR;
        else     state <= state_n;
    end

    // Next-state: advance on each completed word
    always_comb begin
        state_n = state;
        unique case (state)
            S_HDR: begin
                if (wdone) begin
                    if ({1'b0, word} > MAXN)
                        state_n = S_ERR;
                    else if (word == 32'd0)
                        state_n = S_POST;
                    else
                        state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (wdone && (idx + (ADDR_W+1)'(1) == nwords))
                    state_n = S_POST;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (wdone)
                    state_n = (word == acc) ? S_RUN : S_ERR;
            end
`endif
            default: state_n = state;
        endcase
    end

    // Byte assembly, imem write strobe and release outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt    <= 2'd0;
            sh      <= 24'd0;
            nwords  <= '0;
            idx     <= '0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= 32'd0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            acc     <= 32'd0;
`endif
        end else begin
            we_q    <= 1'b0;
            cpu_rst <= (state != S_RUN);
            done    <= (state == S_RUN);
            err     <= (state == S_ERR);
            if (accept) begin
                bcnt <= bcnt + 2'd1;
                sh   <= {bus.in_byte, sh[23:8]};
            end
            if (wdone && state == S_HDR)
                nwords <= word[ADDR_W:0];
            if (wdone && state == S_LOAD) begin
                we_q    <= 1'b1;
                addr_q  <= ADDR_W'(BASE_ADDR) + idx[ADDR_W-1:0];
                wdata_q <= word;
                idx     <= idx + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
                acc     <= acc ^ word;
`endif
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stimulus with a write scoreboard for
// prog_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;
    localparam int AW = 8;
    localparam logic [31:0] W0 = 32'h0010_0513;
    localparam logic [31:0] W1 = 32'h0020_0593;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rst, done, err;
    logic [39:0] sb[$];
    int checks = 0;
    int errors = 0;

    prog_loader_if #(.ADDR_W(AW)) bus();

    prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cpu_rst(cpu_rst),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] obs,
                         input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard on every observed imem write
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            logic [39:0] e;
            e = (sb.size() > 0) ? sb.pop_front() : 'x;
            check("imem_write", {bus.imem_addr, bus.imem_wdata}, e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load2(input int gap, input logic [31:0] cks);
        sb.push_back({8'd0, W0});
        sb.push_back({8'd1, W1});
        send_word(32'd2, gap);
        send_word(W0, gap);
        send_word(W1, gap);
`ifdef LOADER_CHECKSUM_EN
        send_word(cks, gap);
`else
        if (cks != 32'd0) ;
`endif
    endtask

    task automatic expect_release(input string tag);
        check({tag, "_cpu_rst_hold"}, 40'(cpu_rst), 40'd1);
        check({tag, "_done_hold"}, 40'(done), 40'd0);
        @(negedge clk);
        check({tag, "_cpu_rst"}, 40'(cpu_rst), 40'd0);
        check({tag, "_done"}, 40'(done), 40'd1);
        check({tag, "_err"}, 40'(err), 40'd0);
        check({tag, "_sb_empty"}, 40'(sb.size()), 40'd0);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 40'(bus.in_ready), 40'd0);
        check("rst_cpu_rst", 40'(cpu_rst), 40'd1);
        check("rst_we", 40'(bus.imem_we), 40'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 40'(bus.in_ready), 40'd0);
        check("reset_we", 40'(bus.imem_we), 40'd0);
        check("reset_addr", 40'(bus.imem_addr), 40'd0);
        check("reset_wdata", 40'(bus.imem_wdata), 40'd0);
        check("reset_cpu_rst", 40'(cpu_rst), 40'd1);
        check("reset_done", 40'(done), 40'd0);
        check("reset_err", 40'(err), 40'd0);
        rst = 1'b0;

        load2(0, W0 ^ W1);
        expect_release("load2");

        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("run_in_ready", 40'(bus.in_ready), 40'd0);
            check("run_cpu_rst", 40'(cpu_rst), 40'd0);
        end
        bus.in_valid = 1'b0;

        pulse_rst();
        check("rst_done", 40'(done), 40'd0);
        load2(1, W0 ^ W1);
        expect_release("toggle");

        pulse_rst();
        send_word(32'h0000_0101, 0);
        check("ovf_in_ready", 40'(bus.in_ready), 40'd0);
        check("ovf_err_hold", 40'(err), 40'd0);
        @(negedge clk);
        check("ovf_err", 40'(err), 40'd1);
        check("ovf_cpu_rst", 40'(cpu_rst), 40'd1);
        check("ovf_done", 40'(done), 40'd0);

        pulse_rst();
        send_word(32'd0, 0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'd0, 0);
`endif
        expect_release("zero");

        pulse_rst();
        send_word(32'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        pulse_rst();
        load2(0, W0 ^ W1);
        expect_release("midrst");

`ifdef LOADER_CHECKSUM_EN
        pulse_rst();
        load2(0, 32'd0);
        check("badck_err_hold", 40'(err), 40'd0);
        @(negedge clk);
        check("badck_err", 40'(err), 40'd1);
        check("badck_done", 40'(done), 40'd0);
        check("badck_cpu_rst", 40'(cpu_rst), 40'd1);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 40'(sb.size()), 40'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
